// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
// The bubble codes are also used by the ID/EX and EX/MEM pipeline registers.
package hazard_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] BUB_PASS   = 2'b00;
  localparam logic [1:0] BUB_INSERT = 2'b01;
  localparam logic [1:0] BUB_FLUSH  = 2'b10;

endpackage

// File: rtl/hazard_ctrl_load_use.sv
// Combinational load-use compare between the load in EX and the sources in ID.
// Kept separate so a forwarding unit can reuse the same match logic.
module load_use_detect (
  input  logic       load_ex,
  input  logic [4:0] rt_ex,
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  input  logic       useRt_id,
  output logic       load_use_c
);

  always_comb begin
    load_use_c = load_ex && (rt_ex != 5'd0) &&
                 ((rt_ex == rs_id) || (useRt_id && (rt_ex == rt_id)));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use stall, taken-branch flush and MDU occupancy freeze,
// with a saturating count of front-end stall cycles.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = 4,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   regReset,
  input  logic [4:0]             rs_id,
  input  logic [4:0]             rt_id,
  input  logic                   useRt_id,
  input  logic                   mduStart_id,
  input  logic                   load_ex,
  input  logic [4:0]             rt_ex,
  input  logic                   branchTaken_ex,
  output logic                   pcWrite,
  output logic                   ifidWrite,
  output logic                   ifidFlush,
  output logic [1:0]             idexBubble,
  output logic                   mduBusy,
  output logic [STALL_CNT_W-1:0] stallCount
);

  localparam int unsigned CNT_W = $clog2(MDU_LATENCY + 1);

  state_t           state, next_state;
  logic [CNT_W-1:0] mdu_cnt, next_mdu_cnt;
  logic             load_use;

  load_use_detect u_load_use (
    .load_ex    (load_ex),
    .rt_ex      (rt_ex),
    .rs_id      (rs_id),
    .rt_id      (rt_id),
    .useRt_id   (useRt_id),
    .load_use_c (load_use)
  );

  always_ff @(posedge clk or posedge regReset) begin
    if (regReset) begin
      state   <= RUN;
      mdu_cnt <= '0;
    end else begin
      state   <= next_state;
      mdu_cnt <= next_mdu_cnt;
    end
  end

  // Mealy next-state and control outputs; reset overrides everything to flush.
  always_comb begin
    next_state   = state;
    next_mdu_cnt = mdu_cnt;
    pcWrite      = 1'b1;
    ifidWrite    = 1'b1;
    ifidFlush    = 1'b0;
    idexBubble   = BUB_PASS;
    mduBusy      = 1'b0;

    if (regReset) begin
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      ifidFlush  = 1'b1;
      idexBubble = BUB_FLUSH;
    end else begin
      case (state)
        RUN: begin
          if (branchTaken_ex) begin
            ifidFlush  = 1'b1;
            idexBubble = BUB_FLUSH;
          end else if (load_use) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexBubble = BUB_INSERT;
          end else if (mduStart_id) begin
            next_state   = MDU_WAIT;
            next_mdu_cnt = CNT_W'(MDU_LATENCY);
          end
        end
        MDU_WAIT: begin
          pcWrite    = 1'b0;
          ifidWrite  = 1'b0;
          idexBubble = BUB_INSERT;
          mduBusy    = 1'b1;
          if (branchTaken_ex) begin
            ifidFlush  = 1'b1;
            idexBubble = BUB_FLUSH;
          end
          // A zero count can only arise from corruption; leave immediately.
          if (mdu_cnt <= CNT_W'(1)) begin
            next_state   = RUN;
            next_mdu_cnt = '0;
          end else begin
            next_mdu_cnt = mdu_cnt - CNT_W'(1);
          end
        end
        default: begin
          next_state   = RUN;
          next_mdu_cnt = '0;
        end
      endcase
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or posedge regReset) begin
    if (regReset) begin
      stallCount <= '0;
    end else if (!pcWrite && (stallCount != {STALL_CNT_W{1'b1}})) begin
      stallCount <= stallCount + STALL_CNT_W'(1);
    end
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. It watches the ID and EX stages and drives the write-enable, flush and bubble controls of the PC, IF/ID and ID/EX pipeline registers. It resolves three hazards: load-use, taken branch/jump, and a multi-cycle multiply/divide occupancy window. It also keeps a saturating count of front-end stall cycles.

## Interface
Parameters:
- MDU_LATENCY, 4: cycles (≥1) the front end is frozen after a multiply/divide issues to EX.
- STALL_CNT_W, 16: width of the stall-cycle counter.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk  in  1  core clock; controller state updates on posedge (pipeline registers latch on negedge).
  - regReset  in  1  asynchronous, active-high reset.
- Inputs from ID:
  - rs_id  in  5  rs field of the instruction in ID.
  - rt_id  in  5  rt field of the instruction in ID.
  - useRt_id  in  1  instruction in ID reads rt as a source.
  - mduStart_id  in  1  instruction in ID is mult/multu/div/divu.
- Inputs from EX:
  - load_ex  in  1  instruction in EX is lw, lb or lbu.
  - rt_ex  in  5  destination register of the load in EX.
  - branchTaken_ex  in  1  branch or jump resolved taken in EX.
- Outputs:
  - pcWrite  out  1  PC update enable.
  - ifidWrite  out  1  IF/ID load enable.
  - ifidFlush  out  1  clear IF/ID to nop.
  - idexBubble  out  2  ID/EX control: 2'b00 pass, 2'b01 insert bubble, 2'b10 flush.
  - mduBusy  out  1  high while in MDU_WAIT.
  - stallCount  out  STALL_CNT_W  saturating count of cycles with pcWrite=0, excluding reset.

## Operation
- Hazard conditions:
  - loadUse = load_ex && rt_ex!=0 && (rt_ex==rs_id || (useRt_id && rt_ex==rt_id)).
  - Comparisons are 5-bit equality only.
- FSM states: RUN, MDU_WAIT. The counter is mduCnt, width $clog2(MDU_LATENCY+1).
- RUN, priority branch > loadUse > mduStart. Unlisted outputs are pcWrite=1, ifidWrite=1, ifidFlush=0, idexBubble=00.
  - branchTaken_ex: ifidFlush=1, idexBubble=10, pcWrite=1. Stay in RUN. A pending mduStart_id is discarded because it is being flushed.
  - loadUse: pcWrite=0, ifidWrite=0, idexBubble=01. Stay in RUN. The condition self-clears next cycle when the load leaves EX.
  - mduStart_id with no higher-priority event: the mdu op passes into ID/EX (idexBubble=00) and PC/IF/ID advance. Next state is MDU_WAIT with mduCnt=MDU_LATENCY.
- MDU_WAIT:
  - Outputs: pcWrite=0, ifidWrite=0, idexBubble=01, mduBusy=1.
  - mduCnt decrements each cycle. At mduCnt==1 the next state is RUN.
  - loadUse and mduStart_id are ignored in this state.
  - branchTaken_ex still forces ifidFlush=1, idexBubble=10. The count continues.
- stallCount increments on every posedge where pcWrite=0 and it saturates at all-ones.
- Outputs are Mealy (state plus current inputs) and settle before the next negedge.

## Timing
- While regReset=1:
  - Outputs: pcWrite=0, ifidWrite=0, ifidFlush=1, idexBubble=10, mduBusy=0.
  - Internal state: state=RUN, mduCnt=0, stallCount=0.
- On regReset deassertion, the first posedge operates from RUN.
- Load-use costs exactly 1 stall cycle. Branch flush costs 1 cycle with no stall. An mdu op costs MDU_LATENCY stall cycles, beginning the cycle after it leaves ID.
- Reset asserted mid-MDU_WAIT aborts the wait immediately (asynchronous). No residual stall remains after release.
- loadUse and branchTaken_ex asserted in the same cycle resolve to flush only, with pcWrite=1.
- rt_ex==0 never stalls.

## Structure
- Shared package holds:
  - state enum {RUN, MDU_WAIT};
  - bubble codes BUB_PASS=2'b00, BUB_INSERT=2'b01, BUB_FLUSH=2'b10, which ID/EX and EX/MEM registers also use.
- One natural sub-module, load_use_detect: the combinational loadUse compare, reusable by a future forwarding unit.
- Top level: FSM, mduCnt, stallCount, output mux.

## Test plan
- Reset: hold regReset=1 for 3 cycles → pcWrite=0, ifidFlush=1, idexBubble=10, stallCount=0. After release with no hazards → pcWrite=1, idexBubble=00.
- Load-use:
  - load_ex=1, rt_ex=8, rs_id=8 → exactly one cycle of pcWrite=0, ifidWrite=0, idexBubble=01. stallCount goes 0→1.
  - Repeat with rt_ex=0 → no stall.
- rt dependency gated by useRt_id: rt_ex=9, rt_id=9, rs_id=3.
  - With useRt_id=0 → no stall.
  - With useRt_id=1 → 1-cycle stall.
- Branch priority: branchTaken_ex=1 together with loadUse true → ifidFlush=1, idexBubble=10, pcWrite=1, and stallCount unchanged.
- MDU, MDU_LATENCY=4: pulse mduStart_id → next 4 cycles have mduBusy=1, pcWrite=0, idexBubble=01. Then RUN, with stallCount=4.
- Reset during MDU_WAIT: assert regReset on the 2nd wait cycle → mduBusy drops asynchronously. After release, no further stall.
